// File: rtl/soc_gpio_pkg.sv
// Shared definitions for the soc_gpio_pio GPIO controller.
//   - Word addresses of the Avalon-MM register map
//   - Edge capture mode encoding
//   - Helper that turns current/previous debounced levels into edge flags
package soc_gpio_pkg;

  localparam logic [2:0] ADDR_DATA_IN  = 3'd0;
  localparam logic [2:0] ADDR_DATA_OUT = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_OUT_SET  = 3'd4;
  localparam logic [2:0] ADDR_OUT_CLR  = 3'd5;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_mode_e;

  // Works on a full 32-bit word so callers of any pin count can share it;
  // the caller truncates the result to its own width.
  function automatic logic [31:0] edge_select(input edge_mode_e mode,
                                              input logic [31:0] cur,
                                              input logic [31:0] prev);
    logic [31:0] result;
    case (mode)
      EDGE_RISE: result = cur & ~prev;
      EDGE_FALL: result = ~cur & prev;
      default:   result = cur ^ prev;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Single-bit input conditioner: 2-flop synchroniser followed by a debouncer.
// Ports:
//   clk, rst : system clock, asynchronous active-high reset
//   pin      : raw asynchronous input
//   stable   : debounced level; follows pin only after it has differed from
//              the current stable value for DEBOUNCE_CYCLES consecutive clocks
module gpio_debounce
  import soc_gpio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic stable
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;

  // Any cycle where the synchronised level agrees with stable restarts the
  // count, so a glitch shorter than DEBOUNCE_CYCLES never gets through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      meta <= pin;
      sync <= meta;
      if (sync != stable) begin
        if (cnt == CNT_LAST) begin
          stable <= sync;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/soc_gpio_pio.sv
// Parametrised memory-mapped GPIO controller (32-bit Avalon-MM slave).
// Ports:
//   clk, rst              : system clock, asynchronous active-high reset
//   avs_address           : word address (see soc_gpio_pkg for the map)
//   avs_read / avs_write  : bus strobes, no wait states
//   avs_writedata         : write data
//   avs_readdata          : read data, valid with avs_readdatavalid
//   avs_readdatavalid     : pulses one clock after avs_read
//   irq                   : level interrupt, |(edge_cap & irq_mask), registered
//   gpio_in               : asynchronous input pins (debounced internally)
//   gpio_out              : output pins
module soc_gpio_pio
  import soc_gpio_pkg::*;
#(
  parameter int IN_W            = 8,
  parameter int OUT_W           = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_MODE       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             avs_readdatavalid,
  output logic             irq,
  input  logic [IN_W-1:0]  gpio_in,
  output logic [OUT_W-1:0] gpio_out
);

  localparam edge_mode_e MODE = edge_mode_e'(EDGE_MODE);

  logic [IN_W-1:0]  stable;
  logic [IN_W-1:0]  stable_q;
  logic [IN_W-1:0]  edges;
  logic [IN_W-1:0]  edge_cap;
  logic [IN_W-1:0]  edge_clr;
  logic [IN_W-1:0]  irq_mask;
  logic [IN_W-1:0]  wdata_in;
  logic [OUT_W-1:0] wdata_out;
  logic [31:0]      rdata;
  logic             unused_wdata;

  // Bits above IN_W/OUT_W are simply dropped.
  assign wdata_in     = avs_writedata[IN_W-1:0];
  assign wdata_out    = avs_writedata[OUT_W-1:0];
  assign unused_wdata = ^avs_writedata;

  genvar gi;
  generate
    for (gi = 0; gi < IN_W; gi++) begin : g_in
      gpio_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .pin   (gpio_in[gi]),
        .stable(stable[gi])
      );
    end
  endgenerate

  // stable_q resets to the same value as stable, so leaving reset never
  // looks like an edge.
  always_comb begin
    edges    = IN_W'(edge_select(MODE, 32'(stable), 32'(stable_q)));
    edge_clr = (avs_write && avs_address == ADDR_EDGE_CAP) ? wdata_in : '0;
  end

  // Register file. A W1C and a new edge on the same bit resolve to set
  // because the new edges are OR-ed in after the clear mask is applied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_q <= '0;
      edge_cap <= '0;
      irq_mask <= '0;
      gpio_out <= '0;
      irq      <= 1'b0;
    end else begin
      stable_q <= stable;
      edge_cap <= (edge_cap & ~edge_clr) | edges;
      irq      <= |(edge_cap & irq_mask);
      if (avs_write) begin
        case (avs_address)
          ADDR_DATA_OUT: gpio_out <= wdata_out;
          ADDR_IRQ_MASK: irq_mask <= wdata_in;
          ADDR_OUT_SET:  gpio_out <= gpio_out | wdata_out;
          ADDR_OUT_CLR:  gpio_out <= gpio_out & ~wdata_out;
          default: ;
        endcase
      end
    end
  end

  // Read mux sees register values before any same-cycle write lands.
  always_comb begin
    rdata = '0;
    case (avs_address)
      ADDR_DATA_IN:  rdata[IN_W-1:0]  = stable;
      ADDR_DATA_OUT: rdata[OUT_W-1:0] = gpio_out;
      ADDR_IRQ_MASK: rdata[IN_W-1:0]  = irq_mask;
      ADDR_EDGE_CAP: rdata[IN_W-1:0]  = edge_cap;
      default: ;
    endcase
  end

  // Fixed one-cycle read latency; readdata holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= avs_read;
      if (avs_read) begin
        avs_readdata <= rdata;
      end
    end
  end

endmodule

// File: tb/tb_soc_gpio_pio.sv
// Self-checking bench for soc_gpio_pio with DEBOUNCE_CYCLES=4, 8-bit ports.
// Three instances share the bus and pins, one per edge capture mode
// (u_rise = mode 0, u_fall = mode 1, u_both = mode 2); most checks use u_rise.
module tb_soc_gpio_pio;

  logic        clk;
  logic        rst;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [7:0]  gpio_in;

  logic [31:0] rd_rise, rd_fall, rd_both;
  logic        v_rise, v_fall, v_both;
  logic        irq_rise, irq_fall, irq_both;
  logic [7:0]  out_rise, out_fall, out_both;

  logic [31:0] r_rise, r_fall, r_both;

  int n_checks;
  int n_fail;

  typedef struct {
    logic        write;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [7:0]  exp_out;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[15];

  soc_gpio_pio #(.IN_W(8), .OUT_W(8), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0)) u_rise (
    .clk(clk), .rst(rst), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(rd_rise),
    .avs_readdatavalid(v_rise), .irq(irq_rise), .gpio_in(gpio_in), .gpio_out(out_rise));

  soc_gpio_pio #(.IN_W(8), .OUT_W(8), .DEBOUNCE_CYCLES(4), .EDGE_MODE(1)) u_fall (
    .clk(clk), .rst(rst), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(rd_fall),
    .avs_readdatavalid(v_fall), .irq(irq_fall), .gpio_in(gpio_in), .gpio_out(out_fall));

  soc_gpio_pio #(.IN_W(8), .OUT_W(8), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2)) u_both (
    .clk(clk), .rst(rst), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(rd_both),
    .avs_readdatavalid(v_both), .irq(irq_both), .gpio_in(gpio_in), .gpio_out(out_both));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends even if something stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
    avs_address   = addr;
    avs_writedata = data;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_write     = 1'b0;
    avs_writedata = '0;
  endtask

  task automatic bus_read(input logic [2:0] addr);
    avs_address = addr;
    avs_read    = 1'b1;
    @(negedge clk);
    avs_read    = 1'b0;
    check_output("readdatavalid", {31'b0, v_rise}, 32'd1);
    r_rise = rd_rise;
    r_fall = rd_fall;
    r_both = rd_both;
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    if (v.write) begin
      bus_write(v.addr, v.data);
    end else begin
      bus_read(v.addr);
      check_output($sformatf("vec%0d_rdata", idx), r_rise, v.exp_rdata);
    end
    check_output($sformatf("vec%0d_gpio_out", idx), {24'b0, out_rise}, {24'b0, v.exp_out});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Register access table; gpio_out starts at 0, DATA_IN is 0D at this point.
    vecs[0]  = '{1'b1, 3'd1, 32'h0000_00A0, 8'hA0, 32'h0};
    vecs[1]  = '{1'b1, 3'd4, 32'h0000_000F, 8'hAF, 32'h0};
    vecs[2]  = '{1'b1, 3'd5, 32'h0000_0080, 8'h2F, 32'h0};
    vecs[3]  = '{1'b0, 3'd1, 32'h0,         8'h2F, 32'h0000_002F};
    vecs[4]  = '{1'b0, 3'd4, 32'h0,         8'h2F, 32'h0};
    vecs[5]  = '{1'b0, 3'd5, 32'h0,         8'h2F, 32'h0};
    vecs[6]  = '{1'b1, 3'd0, 32'h0000_00FF, 8'h2F, 32'h0};
    vecs[7]  = '{1'b0, 3'd0, 32'h0,         8'h2F, 32'h0000_000D};
    vecs[8]  = '{1'b1, 3'd2, 32'h0000_01FF, 8'h2F, 32'h0};
    vecs[9]  = '{1'b0, 3'd2, 32'h0,         8'h2F, 32'h0000_00FF};
    vecs[10] = '{1'b0, 3'd6, 32'h0,         8'h2F, 32'h0};
    vecs[11] = '{1'b1, 3'd7, 32'h0000_00FF, 8'h2F, 32'h0};
    vecs[12] = '{1'b0, 3'd7, 32'h0,         8'h2F, 32'h0};
    vecs[13] = '{1'b1, 3'd2, 32'h0000_0008, 8'h2F, 32'h0};
    vecs[14] = '{1'b1, 3'd1, 32'hFFFF_FF2F, 8'h2F, 32'h0};

    rst           = 1'b1;
    avs_address   = '0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;
    gpio_in       = '0;
    tick(2);

    // Reset state.
    check_output("rst_readdata", rd_rise, 32'h0);
    check_output("rst_valid", {31'b0, v_rise}, 32'h0);
    check_output("rst_irq", {31'b0, irq_rise}, 32'h0);
    check_output("rst_gpio_out", {24'b0, out_rise}, 32'h0);
    rst = 1'b0;

    // Clean pin change: stable updates on the 6th clock after the change.
    gpio_in = 8'h05;
    tick(5);
    bus_read(3'd0);
    check_output("din_before_latency", r_rise, 32'h0);
    bus_read(3'd0);
    check_output("din_at_latency", r_rise, 32'h05);
    tick(10);
    bus_read(3'd0);
    check_output("din_steady", r_rise, 32'h05);
    bus_read(3'd3);
    check_output("edge_cap_rise_05", r_rise, 32'h05);
    bus_write(3'd3, 32'hFF);
    bus_read(3'd3);
    check_output("edge_cap_w1c", r_rise, 32'h0);

    // Two-clock glitch is rejected, a held level is accepted.
    gpio_in = 8'h0D;
    tick(2);
    gpio_in = 8'h05;
    tick(8);
    bus_read(3'd0);
    check_output("glitch_din", r_rise, 32'h05);
    bus_read(3'd3);
    check_output("glitch_edge_cap", r_rise, 32'h0);
    gpio_in = 8'h0D;
    tick(10);
    bus_read(3'd3);
    check_output("held_edge_cap", r_rise, 32'h08);
    bus_read(3'd0);
    check_output("held_din", r_rise, 32'h0D);

    // Interrupt assert / clear timing.
    bus_write(3'd3, 32'hFF);
    bus_write(3'd2, 32'h08);
    tick(1);
    check_output("irq_idle", {31'b0, irq_rise}, 32'h0);
    gpio_in = 8'h05;
    tick(10);
    bus_read(3'd3);
    check_output("fall_ignored_rise_mode", r_rise, 32'h0);
    gpio_in = 8'h0D;
    tick(7);
    check_output("irq_before_assert", {31'b0, irq_rise}, 32'h0);
    tick(1);
    check_output("irq_assert", {31'b0, irq_rise}, 32'h1);
    bus_write(3'd3, 32'h08);
    check_output("irq_hold_after_w1c", {31'b0, irq_rise}, 32'h1);
    tick(1);
    check_output("irq_clear", {31'b0, irq_rise}, 32'h0);

    // W1C in the same cycle as a new edge: the set wins.
    gpio_in = 8'h05;
    tick(10);
    gpio_in = 8'h0D;
    tick(6);
    bus_write(3'd3, 32'h08);
    tick(1);
    check_output("irq_set_wins", {31'b0, irq_rise}, 32'h1);
    bus_read(3'd3);
    check_output("edge_cap_set_wins", r_rise, 32'h08);

    // Register file vectors.
    for (int i = 0; i < 15; i++) begin
      apply_stimulus(vecs[i], i);
    end

    // Read and write to the same address in one cycle returns the old value.
    avs_address   = 3'd1;
    avs_writedata = 32'h55;
    avs_read      = 1'b1;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;
    check_output("rw_same_valid", {31'b0, v_rise}, 32'h1);
    check_output("rw_same_rdata", rd_rise, 32'h2F);
    check_output("rw_same_gpio_out", {24'b0, out_rise}, 32'h55);

    // Edge modes on bit 0.
    gpio_in = 8'h0C;
    tick(10);
    bus_write(3'd3, 32'hFF);
    bus_read(3'd3);
    check_output("mode_clr_fall", r_fall, 32'h0);
    check_output("mode_clr_both", r_both, 32'h0);
    gpio_in = 8'h0D;
    tick(10);
    bus_read(3'd3);
    check_output("up_rise", r_rise, 32'h01);
    check_output("up_fall", r_fall, 32'h00);
    check_output("up_both", r_both, 32'h01);
    bus_write(3'd3, 32'hFF);
    gpio_in = 8'h0C;
    tick(10);
    bus_read(3'd3);
    check_output("down_rise", r_rise, 32'h00);
    check_output("down_fall", r_fall, 32'h01);
    check_output("down_both", r_both, 32'h01);

    // Asynchronous reset in the middle of a debounce.
    gpio_in = 8'h0D;
    tick(10);
    bus_write(3'd2, 32'h01);
    tick(1);
    check_output("irq_pre_reset", {31'b0, irq_rise}, 32'h1);
    bus_write(3'd1, 32'hFF);
    check_output("gpio_out_pre_reset", {24'b0, out_rise}, 32'hFF);
    bus_read(3'd1);
    check_output("rdata_pre_reset", r_rise, 32'hFF);
    gpio_in = 8'h8D;
    tick(3);
    #2;
    rst = 1'b1;
    #1;
    check_output("async_rst_readdata", rd_rise, 32'h0);
    check_output("async_rst_valid", {31'b0, v_rise}, 32'h0);
    check_output("async_rst_irq", {31'b0, irq_rise}, 32'h0);
    check_output("async_rst_gpio_out", {24'b0, out_rise}, 32'h0);
    @(negedge clk);
    tick(2);
    rst = 1'b0;
    tick(5);
    bus_read(3'd0);
    check_output("post_rst_din_early", r_rise, 32'h0);
    bus_read(3'd0);
    check_output("post_rst_din", r_rise, 32'h8D);
    bus_read(3'd3);
    check_output("post_rst_edge_cap", r_rise, 32'h8D);
    tick(10);
    bus_read(3'd3);
    check_output("post_rst_edge_cap_hold", r_rise, 32'h8D);
    check_output("post_rst_irq_masked", {31'b0, irq_rise}, 32'h0);
    bus_write(3'd3, 32'hFF);
    tick(10);
    bus_read(3'd3);
    check_output("post_rst_edge_once", r_rise, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
